traffic_intersection_controller: RTL

Parametrised multi-phase intersection light controller, successor to the single-approach red/yellow/green controller. Cycles N_PHASES approaches through GREEN -> YELLOW -> ALL_RED clearance in round-robin order. Adds programmable durations, latched pedestrian requests that extend green and drive walk lamps, an external tick enable for a slow time base, and a flashing-yellow fault/night mode. Sits between the system prescaler (tick source) and the lamp driver outputs.

---
 rtl/traffic_intersection_controller.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/traffic_intersection_controller.sv
// Multi-phase intersection light controller.
// Round-robin GREEN -> YELLOW -> ALL_RED per approach, with latched pedestrian
// requests that extend green and light the walk lamp, a tick-gated time base
// and a flashing-yellow mode entered only at the end of an all-red clearance.
module traffic_intersection_controller #(
    parameter int unsigned N_PHASES      = 2,
    parameter int unsigned GREEN_TICKS   = 20,
    parameter int unsigned YELLOW_TICKS  = 4,
    parameter int unsigned ALLRED_TICKS  = 2,
    parameter int unsigned PED_EXT_TICKS = 10,
    parameter int unsigned FLASH_TICKS   = 5,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [N_PHASES-1:0] ped_req,
    input  logic                flash_mode,
    output logic [N_PHASES-1:0] red,
    output logic [N_PHASES-1:0] yellow,
    output logic [N_PHASES-1:0] green,
    output logic [N_PHASES-1:0] walk,
    output logic [2:0]          phase,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        S_GREEN  = 2'd0,
        S_YELLOW = 2'd1,
        S_ALLRED = 2'd2,
        S_FLASH  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_GREEN  = CNT_W'(GREEN_TICKS);
    localparam logic [CNT_W-1:0] C_PEDEXT = CNT_W'(PED_EXT_TICKS);
    localparam logic [CNT_W-1:0] C_YELLOW = CNT_W'(YELLOW_TICKS);
    localparam logic [CNT_W-1:0] C_ALLRED = CNT_W'(ALLRED_TICKS);
    localparam logic [CNT_W-1:0] C_FLASH  = CNT_W'(FLASH_TICKS);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
    localparam logic [2:0]       C_LAST   = 3'(N_PHASES - 1);

    state_t              r_state, w_state_nxt;
    logic [2:0]          r_phase, w_phase_nxt;
    logic [CNT_W-1:0]    r_timer, w_timer_nxt, w_dur;
    logic [N_PHASES-1:0] r_ped_pend, w_ped_pend_nxt;
    logic                r_blink, w_blink_nxt;
    logic                r_ext, w_ext_nxt;
    logic                w_last;
    logic [N_PHASES-1:0] r_red, r_yellow, r_green, r_walk;
    logic [N_PHASES-1:0] w_red_nxt, w_yellow_nxt, w_green_nxt, w_walk_nxt;

    // State, timer, request latch and registered lamp outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_ALLRED;
            r_phase    <= C_LAST;
            r_timer    <= '0;
            r_ped_pend <= '0;
            r_blink    <= 1'b0;
            r_ext      <= 1'b0;
            r_red      <= '1;
            r_yellow   <= '0;
            r_green    <= '0;
            r_walk     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_timer    <= w_timer_nxt;
            r_ped_pend <= w_ped_pend_nxt;
            r_blink    <= w_blink_nxt;
            r_ext      <= w_ext_nxt;
            r_red      <= w_red_nxt;
            r_yellow   <= w_yellow_nxt;
            r_green    <= w_green_nxt;
            r_walk     <= w_walk_nxt;
        end
    end

    // Next-state sequencing, timer, pedestrian latch and lamp decode
    always_comb begin
        w_state_nxt    = r_state;
        w_phase_nxt    = r_phase;
        w_timer_nxt    = r_timer;
        w_ped_pend_nxt = r_ped_pend | ped_req;
        w_blink_nxt    = r_blink;
        w_ext_nxt      = r_ext;
        w_dur          = C_ALLRED;
        w_red_nxt      = '0;
        w_yellow_nxt   = '0;
        w_green_nxt    = '0;
        w_walk_nxt     = '0;

        unique case (r_state)
            S_GREEN:  w_dur = r_ext ? (C_GREEN + C_PEDEXT) : C_GREEN;
            S_YELLOW: w_dur = C_YELLOW;
            S_ALLRED: w_dur = C_ALLRED;
            S_FLASH:  w_dur = C_FLASH;
        endcase

        w_last = tick && (r_timer == w_dur - C_ONE);

        if (tick) begin
            w_timer_nxt = w_last ? '0 : r_timer + C_ONE;
        end

        unique case (r_state)
            S_GREEN: begin
                if (w_last) w_state_nxt = S_YELLOW;
            end
            S_YELLOW: begin
                if (w_last) w_state_nxt = S_ALLRED;
            end
            S_ALLRED: begin
                if (w_last) begin
                    if (flash_mode) begin
                        w_state_nxt = S_FLASH;
                        w_blink_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_GREEN;
                        w_phase_nxt = (r_phase == C_LAST) ? 3'd0 : r_phase + 3'd1;
                        // A request arriving on the entry cycle is served now, not left pending
                        for (int unsigned i = 0; i < N_PHASES; i++) begin
                            if (w_phase_nxt == 3'(i)) begin
                                w_ext_nxt         = w_ped_pend_nxt[i];
                                w_ped_pend_nxt[i] = 1'b0;
                            end
                        end
                    end
                end
            end
            S_FLASH: begin
                if (!flash_mode) begin
                    w_state_nxt = S_ALLRED;
                    w_timer_nxt = '0;
                end else if (w_last) begin
                    w_blink_nxt = ~r_blink;
                end
            end
        endcase

        // Lamps are decoded from the next state so they update with state/phase
        for (int unsigned i = 0; i < N_PHASES; i++) begin
            if (w_state_nxt == S_FLASH) begin
                w_yellow_nxt[i] = w_blink_nxt;
            end else if (w_phase_nxt == 3'(i)) begin
                unique case (w_state_nxt)
                    S_GREEN: begin
                        w_green_nxt[i] = 1'b1;
                        w_walk_nxt[i]  = w_ext_nxt;
                    end
                    S_YELLOW: w_yellow_nxt[i] = 1'b1;
                    default:  w_red_nxt[i]    = 1'b1;
                endcase
            end else begin
                w_red_nxt[i] = 1'b1;
            end
        end
    end

    assign red    = r_red;
    assign yellow = r_yellow;
    assign green  = r_green;
    assign walk   = r_walk;
    assign phase  = r_phase;
    assign state  = r_state;

endmodule
